vector_element_retirer: RTL

VECTOR_ELEMENT_RETIRER -- requirements
Module: vector_element_retirer

---
 rtl/rv32i_types_pkg.sv | 23 ++
 rtl/retire_lane_decode.sv | 26 ++
 rtl/vector_element_retirer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rv32i_types_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv32i_types_pkg
// Brief   : Shared word/offset types and retire-state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package rv32i_types_pkg;

    localparam int NUM_RET_LANES = 2;
    localparam int OFFSET_W      = 5;

    typedef logic [31:0]         word_t;
    typedef logic [OFFSET_W-1:0] offset_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        FAULT  = 2'd3
    } retire_state_t;

endpackage
`default_nettype wire

// File: rtl/retire_lane_decode.sv
`default_nettype none
// ============================================================================
// Module  : retire_lane_decode
// Brief   : Maps the per-lane return mask to an element increment.
// Revision: 1.0 - initial release
// ============================================================================
module retire_lane_decode (
    input  logic [1:0] ret_valid,
    output logic [1:0] increment,
    output logic       legal
);

    // Lanes return in order, so upper-only (2'b10) cannot happen legally.
    always_comb begin
        increment = 2'd0;
        legal     = 1'b1;
        case (ret_valid)
            2'b01:   increment = 2'd1;
            2'b11:   increment = 2'd2;
            2'b10:   legal     = 1'b0;
            default: increment = 2'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vector_element_retirer.sv
`default_nettype none
// ============================================================================
// Module  : vector_element_retirer
// Brief   : Tracks in-order element retirement of a vector instruction.
//           Optional return-order checker: define ELEMENT_RETIRE_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module vector_element_retirer
    import rv32i_types_pkg::*;
#(
    parameter int NUM_RET_LANES = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     start,
    input  word_t                    vl,
    input  word_t                    vstart,
    input  logic [NUM_RET_LANES-1:0] ret_valid,
    input  offset_t                  ret_offset,
    input  logic                     ret_exc,
    input  logic                     flush,
    input  logic                     wb_ack,
    output logic                     busy,
    output logic                     instr_done,
    output logic                     fault,
    output word_t                    vstart_out,
    output word_t                    retired,
    output logic                     seq_err
);

    retire_state_t r_state, w_state_nxt;
    word_t         r_retired, w_retired_nxt;
    word_t         r_vstart_out, w_vstart_out_nxt;
    word_t         r_vl, w_vl_nxt;
    logic          r_seq_err;

    logic [1:0]    w_inc;
    logic          w_legal;
    logic [32:0]   w_sum;
    logic          w_reach_end;

    retire_lane_decode u_decode (
        .ret_valid (ret_valid),
        .increment (w_inc),
        .legal     (w_legal)
    );

    // 33-bit sum so a return near the top of the word range cannot wrap.
    assign w_sum       = {1'b0, r_retired} + {31'd0, w_inc};
    assign w_reach_end = (w_sum >= {1'b0, r_vl});

    always_comb begin
        w_state_nxt      = r_state;
        w_retired_nxt    = r_retired;
        w_vstart_out_nxt = r_vstart_out;
        w_vl_nxt         = r_vl;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_vl_nxt         = vl;
                    w_retired_nxt    = vstart;
                    w_vstart_out_nxt = '0;
                    w_state_nxt      = (vstart >= vl) ? DONE : ACTIVE;
                end
            end
            ACTIVE: begin
                if (ret_valid[0] && ret_exc) begin
                    w_vstart_out_nxt = r_retired;
                    w_state_nxt      = FAULT;
                end else if (w_reach_end) begin
                    w_retired_nxt    = r_vl;
                    w_vstart_out_nxt = '0;
                    w_state_nxt      = DONE;
                end else begin
                    w_retired_nxt    = w_sum[31:0];
                end
            end
            DONE: begin
                w_vstart_out_nxt = '0;
                if (wb_ack) w_state_nxt = IDLE;
            end
            FAULT: begin
                if (wb_ack) begin
                    w_vstart_out_nxt = '0;
                    w_state_nxt      = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_state_nxt      = IDLE;
            w_retired_nxt    = '0;
            w_vstart_out_nxt = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_retired    <= '0;
            r_vstart_out <= '0;
            r_vl         <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_retired    <= w_retired_nxt;
            r_vstart_out <= w_vstart_out_nxt;
            r_vl         <= w_vl_nxt;
        end
    end

`ifdef ELEMENT_RETIRE_CHECK_EN
    logic w_order_bad;
    assign w_order_bad = (r_state == ACTIVE) && !flush &&
                         ((ret_valid[0] && (ret_offset != r_retired[OFFSET_W-1:0])) || !w_legal);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_seq_err <= 1'b0;
        else       r_seq_err <= w_order_bad;
    end
`else
    logic w_unused_check;
    assign w_unused_check = ^{ret_offset, w_legal};
    assign r_seq_err      = 1'b0;
`endif

    assign busy       = (r_state != IDLE);
    assign instr_done = (r_state == DONE);
    assign fault      = (r_state == FAULT);
    assign vstart_out = r_vstart_out;
    assign retired    = r_retired;
    assign seq_err    = r_seq_err;

endmodule
`default_nettype wire
